// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared state encodings and pattern constants for the 1011 detector
package seq_det_pkg;

    localparam int STATE_W = 3;
    localparam logic [3:0] PATTERN = 4'b1011;

    // Each code is the length of the pattern prefix matched so far.
    typedef enum logic [STATE_W-1:0] {
        S0    = 3'd0,
        S1    = 3'd1,
        S10   = 3'd2,
        S101  = 3'd3,
        S1011 = 3'd4
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating match counter with sticky overflow flag
module sat_counter #(
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Clear,
    input  logic                   Inc,
    output logic [COUNT_WIDTH-1:0] Count,
    output logic                   Overflow
);

    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    // Clear shares priority with Reset so a colliding increment is dropped.
    always_ff @(posedge Clock) begin
        if (Reset || Clear) begin
            Count    <= '0;
            Overflow <= 1'b0;
        end else if (Inc) begin
            if (Count == COUNT_MAX) begin
                Overflow <= 1'b1;
            end else begin
                Count <= Count + COUNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/seq1011_detector.sv
// rtl/seq1011_detector.sv - Moore detector for overlapping 1011 with saturating match count
module seq1011_detector
    import seq_det_pkg::*;
#(
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   En,
    input  logic                   Din,
    input  logic                   Clear,
    output logic                   Match,
    output logic [COUNT_WIDTH-1:0] MatchCount,
    output logic                   Overflow,
    output logic [STATE_W-1:0]     State
);

    state_t state_q;
    state_t state_d;
    logic   match_event;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // Illegal codes fall back to S0 even when En is low.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S0:    if (En) state_d = Din ? S1    : S0;
            S1:    if (En) state_d = Din ? S1    : S10;
            S10:   if (En) state_d = Din ? S101  : S0;
            S101:  if (En) state_d = Din ? S1011 : S10;
            S1011: if (En) state_d = Din ? S1    : S10;
            default:       state_d = S0;
        endcase
    end

    always_comb begin
        match_event = En && (state_d == S1011);
    end

    assign Match = (state_q == S1011);
    assign State = state_q;

    sat_counter #(
        .COUNT_WIDTH(COUNT_WIDTH)
    ) u_sat_counter (
        .Clock   (Clock),
        .Reset   (Reset),
        .Clear   (Clear),
        .Inc     (match_event),
        .Count   (MatchCount),
        .Overflow(Overflow)
    );

endmodule

// File: tb/tb_seq1011_detector.sv
// tb/tb_seq1011_detector.sv - self-checking bench for seq1011_detector at widths 8 and 2
module tb_seq1011_detector;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       En    = 1'b0;
    logic       Din   = 1'b0;
    logic       Clear = 1'b0;

    logic       match8, ovf8;
    logic [7:0] cnt8;
    logic [2:0] st8;
    logic       match2, ovf2;
    logic [1:0] cnt2;
    logic [2:0] st2;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: last sampled bits since reset plus two counters.
    int  hist[$];
    int  m_cnt8 = 0;
    bit  m_ovf8 = 1'b0;
    int  m_cnt2 = 0;
    bit  m_ovf2 = 1'b0;

    always #5 Clock = ~Clock;

    seq1011_detector #(.COUNT_WIDTH(8)) dut8 (
        .Clock(Clock), .Reset(Reset), .En(En), .Din(Din), .Clear(Clear),
        .Match(match8), .MatchCount(cnt8), .Overflow(ovf8), .State(st8)
    );

    seq1011_detector #(.COUNT_WIDTH(2)) dut2 (
        .Clock(Clock), .Reset(Reset), .En(En), .Din(Din), .Clear(Clear),
        .Match(match2), .MatchCount(cnt2), .Overflow(ovf2), .State(st2)
    );

    // Longest suffix of the sampled history that is a prefix of 1011.
    function automatic int exp_state();
        logic [3:0] pat;
        bit ok;
        pat = 4'b1011;
        for (int k = 4; k >= 1; k--) begin
            if (hist.size() >= k) begin
                ok = 1'b1;
                for (int i = 0; i < k; i++)
                    if (hist[hist.size() - k + i] != int'(pat[3 - i])) ok = 1'b0;
                if (ok) return k;
            end
        end
        return 0;
    endfunction

    task automatic model_update(input logic en, input logic din, input logic clr, input logic rst);
        bit ev;
        ev = 1'b0;
        if (rst) begin
            hist.delete();
            m_cnt8 = 0; m_ovf8 = 1'b0;
            m_cnt2 = 0; m_ovf2 = 1'b0;
        end else begin
            if (en) begin
                hist.push_back(int'(din));
                if (hist.size() > 4) void'(hist.pop_front());
                ev = (exp_state() == 4);
            end
            if (clr) begin
                m_cnt8 = 0; m_ovf8 = 1'b0;
                m_cnt2 = 0; m_ovf2 = 1'b0;
            end else if (ev) begin
                if (m_cnt8 < 255) m_cnt8++; else m_ovf8 = 1'b1;
                if (m_cnt2 < 3)   m_cnt2++; else m_ovf2 = 1'b1;
            end
        end
    endtask

    task automatic step(input logic en, input logic din, input logic clr, input logic rst);
        @(negedge Clock);
        En = en; Din = din; Clear = clr; Reset = rst;
        @(posedge Clock);
        model_update(en, din, clr, rst);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b0, 1'b1);
        vectors++;
        if (st8 !== 3'd0) begin
            miscompares++; $display("FAIL reset_state got %0d expected 0", st8);
        end
        vectors++;
        if ({match8, ovf8, cnt8} !== 10'd0) begin
            miscompares++; $display("FAIL reset_outputs got match=%0b ovf=%0b cnt=%0d expected 0/0/0", match8, ovf8, cnt8);
        end
        vectors++;
        if ({match2, ovf2, cnt2, st2} !== 7'd0) begin
            miscompares++; $display("FAIL reset_w2 got match=%0b ovf=%0b cnt=%0d st=%0d expected all 0", match2, ovf2, cnt2, st2);
        end
    endtask

    task automatic test_basic();
        logic [3:0] bits;
        int exp_st[4] = '{1, 2, 3, 4};
        bits = 4'b1011;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, bits[3 - i], 1'b0, 1'b0);
            vectors++;
            if (st8 !== 3'(exp_st[i]) || match8 !== (i == 3)) begin
                miscompares++;
                $display("FAIL basic_bit%0d got st=%0d match=%0b expected st=%0d match=%0b", i, st8, match8, exp_st[i], (i == 3));
            end
        end
        vectors++;
        if (cnt8 !== 8'd1 || ovf8 !== 1'b0) begin
            miscompares++; $display("FAIL basic_count got cnt=%0d ovf=%0b expected 1/0", cnt8, ovf8);
        end
    endtask

    task automatic test_overlap();
        logic [6:0] bits;
        logic [3:0] tail;
        bits = 7'b1011011;
        tail = 4'b1001;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, bits[6 - i], 1'b0, 1'b0);
            vectors++;
            if (match8 !== (i == 3 || i == 6)) begin
                miscompares++; $display("FAIL overlap_match bit%0d got %0b expected %0b", i, match8, (i == 3 || i == 6));
            end
        end
        vectors++;
        if (cnt8 !== 8'd2) begin
            miscompares++; $display("FAIL overlap_count got %0d expected 2", cnt8);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, tail[3 - i], 1'b0, 1'b0);
            vectors++;
            if (match8 !== 1'b0) begin
                miscompares++; $display("FAIL nomatch bit%0d got match=%0b expected 0", i, match8);
            end
        end
        vectors++;
        if (st8 !== 3'd1 || cnt8 !== 8'd2) begin
            miscompares++; $display("FAIL nomatch_end got st=%0d cnt=%0d expected 1/2", st8, cnt8);
        end
    endtask

    task automatic test_enable();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'(i), 1'b0, 1'b0);
            vectors++;
            if (st8 !== 3'd3 || match8 !== 1'b0) begin
                miscompares++; $display("FAIL enable_hold cyc%0d got st=%0d match=%0b expected 3/0", i, st8, match8);
            end
        end
        step(1'b1, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (match8 !== 1'b1 || cnt8 !== 8'd1) begin
            miscompares++; $display("FAIL enable_match got match=%0b cnt=%0d expected 1/1", match8, cnt8);
        end
    endtask

    task automatic send_1011(input logic clr_last);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, clr_last, 1'b0);
    endtask

    task automatic test_saturation_and_collision();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int n = 1; n <= 5; n++) begin
            send_1011(1'b0);
            vectors++;
            if (cnt2 !== 2'((n > 3) ? 3 : n) || ovf2 !== (n >= 4)) begin
                miscompares++;
                $display("FAIL sat_match%0d got cnt=%0d ovf=%0b expected %0d/%0b", n, cnt2, ovf2, (n > 3) ? 3 : n, (n >= 4));
            end
        end
        vectors++;
        if (cnt8 !== 8'd5 || ovf8 !== 1'b0) begin
            miscompares++; $display("FAIL sat_w8 got cnt=%0d ovf=%0b expected 5/0", cnt8, ovf8);
        end
        send_1011(1'b1);
        vectors++;
        if (cnt8 !== 8'd0 || ovf8 !== 1'b0 || match8 !== 1'b1) begin
            miscompares++; $display("FAIL collision got cnt=%0d ovf=%0b match=%0b expected 0/0/1", cnt8, ovf8, match8);
        end
        vectors++;
        if (cnt2 !== 2'd0 || ovf2 !== 1'b0) begin
            miscompares++; $display("FAIL sat_clear got cnt=%0d ovf=%0b expected 0/0", cnt2, ovf2);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (st8 !== 3'd1 || match8 !== 1'b0 || cnt8 !== 8'd0) begin
            miscompares++; $display("FAIL reset_mid got st=%0d match=%0b cnt=%0d expected 1/0/0", st8, match8, cnt8);
        end
    endtask

    task automatic test_random();
        logic en, din, clr, rst;
        int es;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 600; i++) begin
            en  = ($urandom_range(0, 3) != 0);
            din = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 39) == 0);
            rst = ($urandom_range(0, 99) == 0);
            step(en, din, clr, rst);
            es = exp_state();
            vectors++;
            if (st8 !== 3'(es) || match8 !== (es == 4)) begin
                miscompares++; $display("FAIL rand_fsm i=%0d got st=%0d match=%0b expected %0d/%0b", i, st8, match8, es, (es == 4));
            end
            vectors++;
            if (cnt8 !== 8'(m_cnt8) || ovf8 !== m_ovf8) begin
                miscompares++; $display("FAIL rand_cnt8 i=%0d got %0d/%0b expected %0d/%0b", i, cnt8, ovf8, m_cnt8, m_ovf8);
            end
            vectors++;
            if (st2 !== 3'(es) || cnt2 !== 2'(m_cnt2) || ovf2 !== m_ovf2) begin
                miscompares++; $display("FAIL rand_w2 i=%0d got st=%0d cnt=%0d ovf=%0b expected %0d/%0d/%0b", i, st2, cnt2, ovf2, es, m_cnt2, m_ovf2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overlap();
        test_enable();
        test_saturation_and_collision();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seq1011_detector.md
Name: seq1011_detector

Overview:
Moore-type serial pattern detector that consumes the 1-bit data stream produced by the team's D-latch storage stage. Its Din is driven directly from the latch's Q output.
- Samples Din on Clock edges while En is high.
- Flags every occurrence of the pattern 1011, with overlaps allowed.
- Keeps a saturating count of matches for the later display/readout stage.

Parameters:
COUNT_WIDTH, 8, width of the match counter (minimum 2).

Ports:
Clock  input  1  system clock; all state updates on the rising edge.
Reset  input  1  synchronous, active-high reset.
En  input  1  sample enable; Din is consumed only on edges where En=1.
Din  input  1  serial data bit, driven from the latch Q.
Clear  input  1  synchronous clear of MatchCount and Overflow; FSM is not affected.
Match  output  1  high while the FSM is in state S1011 (Moore output).
MatchCount  output  COUNT_WIDTH  number of matches since reset/clear; saturating.
Overflow  output  1  sticky; set when a match occurs while MatchCount is already at its maximum.
State  output  3  current FSM state encoding, for debug and verification.

Behaviour:
- Reset is synchronous, active-high, and has priority over everything. On the edge where Reset=1:
  - State=S0, Match=0, MatchCount=0, Overflow=0.
  - En, Din and Clear are ignored.
- FSM states and encodings: S0=0 (no prefix), S1=1 ("1"), S10=2 ("10"), S101=3 ("101"), S1011=4 (full match). Codes 5-7 are illegal and go to S0 on the next edge regardless of En.
- Transitions, on edges with En=1:
  - S0: Din=1 -> S1; Din=0 -> S0.
  - S1: Din=0 -> S10; Din=1 -> S1.
  - S10: Din=1 -> S101; Din=0 -> S0.
  - S101: Din=1 -> S1011; Din=0 -> S10.
  - S1011: Din=1 -> S1; Din=0 -> S10. These are the overlap suffixes.
- En=0: State holds, so Match holds its value. No counter activity.
- Latency: the 4th pattern bit is sampled on edge k; Match=1 in the cycle after edge k. Match stays high for exactly one sampled bit (it drops at the next En=1 edge).
- Counter:
  - A match event occurs on any edge with En=1 whose next state is S1011.
  - On a match event, MatchCount increments by 1 if below 2^COUNT_WIDTH-1.
  - If MatchCount is already at the maximum, it holds and Overflow is set to 1.
- Overflow stays set until Reset or Clear.
- Clear=1 (without Reset): MatchCount=0 and Overflow=0 on that edge. The FSM still advances normally.
- Clear and a match event on the same edge: Clear wins, so MatchCount=0 and Overflow=0. Match still asserts the next cycle.
- Reset mid-pattern discards the partial prefix; detection restarts from S0.
- All outputs are registered or decoded from registers only. There is no combinational path from Din to Match.

Decomposition:
- Shared package seq_det_pkg contains:
  - the state encoding constants S0..S1011 (3-bit);
  - the constant PATTERN = 4'b1011;
  - the state width constant STATE_W = 3.
- One natural sub-module: sat_counter, a parameterised COUNT_WIDTH saturating incrementer.
  - Inputs: Clock, Reset, Clear, Inc.
  - Outputs: Count, Overflow.
  - seq1011_detector instantiates it, with Inc driven by the match event.

Test Plan:
1. Basic match: Reset, then En=1 with Din=1,0,1,1 -> State goes 1,2,3,4; Match=1 after the 4th edge only; MatchCount=1; Overflow=0.
2. Overlap and no-match: Din=1,0,1,1,0,1,1 -> Match pulses after bit 4 and bit 7; MatchCount=2. Then Din=1,0,0,1 -> no match; State ends at S1.
3. Enable gating: send 1,0,1 with En=1, hold En=0 for 3 cycles with Din toggling, then send 1 with En=1 -> State stays 3 through the gap; match on the final bit; MatchCount=1.
4. Saturation (COUNT_WIDTH=2): 4 non-overlapped matches -> MatchCount=3 and Overflow=1 after the 4th; a 5th match keeps 3/1; Clear -> 0/0.
5. Reset mid-pattern: Din=1,0,1, then Reset for one edge, then Din=1 -> State=S1; Match=0; MatchCount=0.
6. Clear collision: assert Clear on the edge sampling the final 1 of 1011 with MatchCount=5 -> MatchCount=0, Overflow=0, Match=1 the next cycle.
